pc_fetch: RTL and testbench

//  Program-counter / fetch stage of the single-cycle CPU. Holds the PC, drives the instruction-memory address,

---
 rtl/cpu_pkg.sv | 13 +
 rtl/return_stack.sv | 60 ++++++
 rtl/pc_fetch.sv | 131 +++++++++++++
 tb/tb_pc_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle CPU fetch stage: special opcodes and the fetch-state encoding.
package cpu_pkg;

  localparam logic [7:0] OP_HALT = 8'hFF;
  localparam logic [7:0] OP_CALL = 8'h19;
  localparam logic [7:0] OP_RET  = 8'h1A;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: a push into a full stack overwrites the oldest entry, and the top entry is readable combinationally.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [PTR_W-1:0] w_ptr_dec;

  // r_wr_ptr is the next free slot; once the stack is full, that slot also holds the oldest entry.
  assign w_ptr_inc = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_ptr_dec = (r_wr_ptr == '0) ? PTR_LAST : r_wr_ptr - 1'b1;

  assign full     = (r_count == CNT_FULL);
  assign empty    = (r_count == '0);
  assign top_data = r_mem[w_ptr_dec];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          r_mem[gi] <= '0;
        else if (push && (r_wr_ptr == PTR_W'(gi)))
          r_mem[gi] <= push_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (push) begin
      r_wr_ptr <= w_ptr_inc;
      if (!full)
        r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_wr_ptr <= w_ptr_dec;
      r_count  <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: holds the PC, selects the next PC, and provides a HALT state and a retired-instruction counter.
// When FETCH_RAS_EN is defined, CALL/RET opcodes use a return_stack and a sticky ras_err flag is added.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int         PC_W      = 10,
  parameter int         INSTR_W   = 32,
  parameter logic [7:0] HALT_OP   = OP_HALT,
  parameter int         CNT_W     = 16,
  parameter int         RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr,
  input  logic               s_inc,
  input  logic               s_rel_pc,
  output logic [PC_W-1:0]    pc,
  output logic [7:0]         opcode,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
  output logic               ras_err
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_next;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_sel;
  logic [PC_W-1:0]  w_target;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_unused;

  assign opcode   = instr[INSTR_W-1 -: 8];
  assign w_target = instr[PC_W-1:0];
  assign w_pc_inc = r_pc + 1'b1;
  assign w_unused = ^instr;

  // Sign extension is implicit: the target is already PC_W wide and the sum wraps modulo 2^PC_W.
  always_comb begin
    w_pc_sel = w_pc_inc;
    if (!s_inc)
      w_pc_sel = s_rel_pc ? (r_pc + w_target) : w_target;
  end

`ifdef FETCH_RAS_EN
  logic            w_push;
  logic            w_pop;
  logic            w_ras_fault;
  logic            w_ras_full;
  logic            w_ras_empty;
  logic [PC_W-1:0] w_ras_top;
  logic            r_ras_err;

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top_data  (w_ras_top),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_retire     = 1'b0;
`ifdef FETCH_RAS_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ras_fault = 1'b0;
`endif
    if (r_state == ST_RUN && !stall) begin
      w_retire = 1'b1;
      if (opcode == HALT_OP) begin
        w_state_next = ST_HALT;
`ifdef FETCH_RAS_EN
      end else if (opcode == OP_CALL) begin
        w_push      = 1'b1;
        w_ras_fault = w_ras_full;
        w_pc_next   = w_target;
      end else if (opcode == OP_RET) begin
        w_pop       = 1'b1;
        w_ras_fault = w_ras_empty;
        w_pc_next   = w_ras_empty ? w_pc_inc : w_ras_top;
`endif
      end else begin
        w_pc_next = w_pc_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_retire)
        r_retired <= r_retired + 1'b1;
    end
  end

`ifdef FETCH_RAS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ras_err <= 1'b0;
    else if (w_ras_fault)
      r_ras_err <= 1'b1;
  end

  assign ras_err = r_ras_err;
`else
  assign ras_err = 1'b0;
`endif

  assign pc      = r_pc;
  assign retired = r_retired;
  assign halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; the CALL/RET checks are compiled in only when FETCH_RAS_EN is defined.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] instr;
  logic        s_inc;
  logic        s_rel_pc;
  logic [9:0]  pc;
  logic [7:0]  opcode;
  logic        halted;
  logic [15:0] retired;
  logic        ras_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .instr    (instr),
    .s_inc    (s_inc),
    .s_rel_pc (s_rel_pc),
    .pc       (pc),
    .opcode   (opcode),
    .halted   (halted),
    .retired  (retired),
    .ras_err  (ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [9:0] low);
    return {op, 14'h0, low};
  endfunction

  task automatic drive(input logic st, input logic inc, input logic rel, input logic [31:0] ins);
    stall    = st;
    s_inc    = inc;
    s_rel_pc = rel;
    instr    = ins;
  endtask

  // Inputs change on the falling edge; outputs are observed on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic jump(input logic [9:0] tgt);
    drive(1'b0, 1'b0, 1'b0, mk(8'h00, tgt));
    step();
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b0, mk(8'h00, 10'h0));
    do_reset();
    check("reset_pc", pc, 0);
    check("reset_halted", halted, 0);
    check("reset_retired", retired, 0);
    check("reset_ras_err", ras_err, 0);
    check("opcode_comb", opcode, 8'h00);

    // 1: sequential fetch
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, mk(8'h00, 10'h155));
      step();
      check($sformatf("seq_pc%0d", i), pc, i);
    end
    check("seq_retired", retired, 5);

    // 2: relative with negative offset, and PC wrap
    jump(10'h008);
    check("abs_pc8", pc, 10'h008);
    drive(1'b0, 1'b0, 1'b1, mk(8'h00, 10'h3FE));
    step();
    check("rel_neg", pc, 10'h006);
    jump(10'h3FF);
    check("abs_max", pc, 10'h3FF);
    drive(1'b0, 1'b1, 1'b0, mk(8'h00, 10'h000));
    step();
    check("inc_wrap", pc, 10'h000);
    check("retired_9", retired, 9);

    // 3: absolute target, then stall hold
    jump(10'h003);
    drive(1'b0, 1'b0, 1'b0, mk(8'hA5, 10'h120));
    check("opcode_a5", opcode, 8'hA5);
    step();
    check("abs_120", pc, 10'h120);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, mk(8'h00, 10'h055));
      step();
      check($sformatf("stall_pc%0d", i), pc, 10'h120);
      check($sformatf("stall_ret%0d", i), retired, 11);
    end

    // CALL opcode: a jump with the stack enabled, an ordinary sequential fetch without it
    drive(1'b0, 1'b1, 1'b0, mk(8'h19, 10'h040));
    step();
`ifdef FETCH_RAS_EN
    check("call_opcode", pc, 10'h040);
`else
    check("call_opcode", pc, 10'h121);
    check("ras_err_tied", ras_err, 0);
`endif

    // 4: HALT is ignored while stalled, then freezes the stage
    jump(10'h007);
    check("pre_halt_ret", retired, 13);
    drive(1'b1, 1'b1, 1'b0, mk(8'hFF, 10'h000));
    step();
    check("halt_stalled", halted, 0);
    drive(1'b0, 1'b1, 1'b0, mk(8'hFF, 10'h000));
    step();
    check("halted", halted, 1);
    check("halt_pc", pc, 10'h007);
    check("halt_ret", retired, 14);
    drive(1'b0, 1'b1, 1'b0, mk(8'h00, 10'h000));
    for (int i = 0; i < 10; i++) step();
    check("halt_hold_pc", pc, 10'h007);
    check("halt_hold_ret", retired, 14);
    check("halt_hold", halted, 1);
    #2 reset = 1'b1;
    #1;
    check("async_pc", pc, 0);
    check("async_halted", halted, 0);
    check("async_ret", retired, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_reset_pc", pc, 1);

`ifdef FETCH_RAS_EN
    // 5: CALL/RET round trip, then overflow
    do_reset();
    jump(10'h004);
    drive(1'b0, 1'b1, 1'b0, mk(8'h19, 10'h040));
    step();
    check("call_pc", pc, 10'h040);
    drive(1'b0, 1'b0, 1'b0, mk(8'h1A, 10'h200));
    step();
    check("ret_pc", pc, 10'h005);
    drive(1'b1, 1'b1, 1'b0, mk(8'h19, 10'h300));
    step();
    check("call_stalled", pc, 10'h005);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, mk(8'h19, 10'h100 + 10'(i)));
      step();
      check($sformatf("ovf_err%0d", i), ras_err, (i == 4) ? 1 : 0);
    end
    check("ovf_pc", pc, 10'h104);
    drive(1'b0, 1'b1, 1'b0, mk(8'h1A, 10'h000));
    step();
    check("ret_newest", pc, 10'h104);
    step(); step(); step();
    check("ret_oldest_kept", pc, 10'h101);
    step();
    check("ret_after_drain", pc, 10'h102);

    // 6: RET on an empty stack
    do_reset();
    check("ras_reset", ras_err, 0);
    jump(10'h009);
    drive(1'b0, 1'b0, 1'b1, mk(8'h1A, 10'h050));
    step();
    check("unf_pc", pc, 10'h00A);
    check("unf_err", ras_err, 1);
    drive(1'b0, 1'b1, 1'b0, mk(8'h00, 10'h000));
    step(); step();
    check("unf_sticky", ras_err, 1);
    do_reset();
    check("unf_cleared", ras_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
